rv_multicycle_ctrl: RTL and testbench
=====================================

# rv_multicycle_ctrl

Moore-style control FSM for the multicycle RV32I core. It sequences instruction fetch, decode, execute, memory access and writeback over a shared ALU and a single memory port, stalling on a memory-ready handshake. It drives immediate-format selection to the immediate extender, ALU operand and result muxes, and register, PC and IR write enables. It also decodes the ALU operation from funct3/funct7.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_write  out  1  request is a store
- adr_src  out  1  memory address: 0 = PC, 1 = ALUOut
- ir_write  out  1  latch instruction and OldPC
- pc_write  out  1  PC <= result
- reg_write  out  1  register file write
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- alu_src_b  out  2  00 = rs2, 01 = Imm, 10 = constant 4
- result_src  out  2  00 = ALUOut, 01 = read data, 10 = ALU result
- imm_sel  out  3  000 = I, 001 = S, 010 = B, 011 = U, 100 = J
- alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- illegal  out  1  sticky illegal-instruction flag

## Operation
- States: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BRANCH, UTYPE, HALT.
- All outputs are 0 unless listed. alu_ctrl is add unless listed.
- IDLE: moves to FETCH unconditionally.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, result_src=10. Holds while mem_ready=0. On mem_ready=1, pulses ir_write and pc_write for that cycle only, then goes to DECODE.
- DECODE: a=01, b=01, imm_sel=J for jal, else B. Dispatch on op:
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BRANCH
  - 0110111/0010111 -> UTYPE
  - anything else -> HALT, with illegal set
- MEMADR: a=10, b=01, imm_sel = I (load) or S (store). Goes to MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req=1, adr_src=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1. Goes to FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Waits for mem_ready, then goes to FETCH.
- EXECR: a=10, b=00, alu_ctrl from funct3/funct7b5. Goes to ALUWB.
- EXECI: a=10, b=01, imm_sel=I, alu_ctrl from funct3 (funct7b5 ignored except for shift). Goes to ALUWB.
- ALU decode by funct3:
  - 000: add; sub when R-type and funct7b5=1
  - 111: and; 110: or; 100: xor; 010: slt; 001: sll
  - 101: srl when funct7b5=0; sra (funct7b5=1) is illegal -> HALT
  - 011 (sltu): illegal -> HALT
- ALUWB: result_src=00, reg_write=1. Goes to FETCH.
- JAL: a=01, b=10, result_src=00, pc_write=1 (PC <= target held in ALUOut). Goes to ALUWB, which writes OldPC+4.
- BRANCH: a=10, b=00, alu_ctrl=sub, result_src=00.
  - funct3=000 (beq): pc_write = zero.
  - funct3=001 (bne): pc_write = ~zero.
  - Other funct3: illegal -> HALT.
  - Otherwise goes to FETCH.
- UTYPE: imm_sel=U, b=01; a=11 for lui, a=01 for auipc. Goes to ALUWB.
- HALT: absorbing. All outputs 0 except illegal=1. Exits only on reset.

## Timing
- Reset (async, any state, including mid-request): state=IDLE, illegal=0, all outputs 0 immediately.
- First mem_req: the second rising edge after rst_n deasserts.
- Cycles per instruction with zero-wait memory (mem_ready=1 on the first request cycle):
  - branch: 3
  - R, I, sw, jal, lui, auipc: 4
  - lw: 5
- Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- While stalled, mem_req, mem_write and adr_src stay stable.
- ir_write and pc_write are never asserted during a stall.
- mem_ready is ignored outside request states.
- reg_write and mem_write are never asserted in the same cycle.

## Configuration
- RV_UTYPE_EN defined: lui/auipc decode to UTYPE as above.
- RV_UTYPE_EN undefined: opcodes 0110111 and 0010111 are illegal (DECODE -> HALT, illegal=1). The UTYPE state and the a=11 selection are removed.

## Test plan
- Reset mid-MEMREAD with rst_n=0 -> outputs 0 the same cycle. After release: IDLE, then FETCH with mem_req=1.
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), mem_ready tied high -> FETCH, DECODE, EXECR (alu_ctrl=000), ALUWB (reg_write=1). 4 cycles; then back in FETCH.
- lw with mem_ready low for 2 cycles in MEMREAD -> 7 cycles total; adr_src=1 held through the stall; reg_write only in MEMWB with result_src=01.
- beq with zero=1 vs zero=0 -> pc_write=1 vs 0 in BRANCH; 3 cycles; imm_sel=010 in DECODE.
- jal -> imm_sel=100 in DECODE; pc_write=1 in JAL; reg_write=1 in ALUWB.
- op 1110011 -> HALT, illegal=1, held for 20 cycles. Separately, lui with RV_UTYPE_EN undefined -> illegal=1; with it defined -> a=11, imm_sel=011.

Source files
------------

// File: rtl/rv_multicycle_ctrl_if.sv
// rv_multicycle_ctrl_if: bundle between the multicycle control FSM and its datapath.
//   master : controller side. It receives the instruction fields, the ALU zero flag and
//            mem_ready, and drives the memory request, the write enables, the mux selects,
//            alu_ctrl and the sticky illegal flag.
//   slave  : datapath/memory side, with the opposite directions.
interface rv_multicycle_ctrl_if;
    // Instruction fields from the IR, plus datapath and memory status.
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    // Control outputs.
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] imm_sel;
    logic [2:0] alu_ctrl;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
        output alu_src_a, alu_src_b, result_src, imm_sel, alu_ctrl, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
        input  alu_src_a, alu_src_b, result_src, imm_sel, alu_ctrl, illegal
    );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: Moore-style control FSM for a multicycle RV32I core.
// It runs fetch, decode, execute, memory access and writeback over one ALU and one memory
// port. It stalls in the request states until mem_ready is high.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset. It returns the FSM to IDLE and clears illegal.
//   bus_if : rv_multicycle_ctrl_if.master. It carries the instruction fields, zero and
//            mem_ready in, and the memory handshake, the mux selects, the enables,
//            alu_ctrl and illegal out.
// Configuration macro:
//   RV_UTYPE_EN : when defined, lui/auipc are decoded. When it is not defined, both
//                 opcodes are illegal.
// Every output except illegal is decoded from the current state. mem_ready qualifies the
// fetch write enables, and zero qualifies the branch pc_write. illegal is a sticky
// register that is set on entry to HALT.
module rv_multicycle_ctrl (
    input  logic                 clk,
    input  logic                 rst_n,
    rv_multicycle_ctrl_if.master bus_if
);
    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 7;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CODE_W  = 3;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
`ifdef RV_UTYPE_EN
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
`endif

    localparam logic [SEL_W-1:0] A_PC    = 2'b00;
    localparam logic [SEL_W-1:0] A_OLDPC = 2'b01;
    localparam logic [SEL_W-1:0] A_RS1   = 2'b10;
`ifdef RV_UTYPE_EN
    localparam logic [SEL_W-1:0] A_ZERO  = 2'b11;
`endif
    localparam logic [SEL_W-1:0] B_RS2   = 2'b00;
    localparam logic [SEL_W-1:0] B_IMM   = 2'b01;
    localparam logic [SEL_W-1:0] B_FOUR  = 2'b10;
    localparam logic [SEL_W-1:0] R_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] R_RDATA  = 2'b01;
    localparam logic [SEL_W-1:0] R_ALU    = 2'b10;

    localparam logic [CODE_W-1:0] IMM_I = 3'b000;
    localparam logic [CODE_W-1:0] IMM_S = 3'b001;
    localparam logic [CODE_W-1:0] IMM_B = 3'b010;
`ifdef RV_UTYPE_EN
    localparam logic [CODE_W-1:0] IMM_U = 3'b011;
`endif
    localparam logic [CODE_W-1:0] IMM_J = 3'b100;

    localparam logic [CODE_W-1:0] ALU_ADD = 3'b000;
    localparam logic [CODE_W-1:0] ALU_SUB = 3'b001;
    localparam logic [CODE_W-1:0] ALU_AND = 3'b010;
    localparam logic [CODE_W-1:0] ALU_OR  = 3'b011;
    localparam logic [CODE_W-1:0] ALU_XOR = 3'b100;
    localparam logic [CODE_W-1:0] ALU_SLT = 3'b101;
    localparam logic [CODE_W-1:0] ALU_SLL = 3'b110;
    localparam logic [CODE_W-1:0] ALU_SRL = 3'b111;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH,
`ifdef RV_UTYPE_EN
        S_UTYPE,
`endif
        S_HALT
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q;

    logic              mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [SEL_W-1:0]  alu_src_a, alu_src_b, result_src;
    logic [CODE_W-1:0] imm_sel, alu_ctrl;
    logic [CODE_W:0]   alu_dec_r, alu_dec_i;

    // ALU operation decode; the top bit flags sltu and sra/srai as unsupported.
    function automatic logic [CODE_W:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                                    input logic is_r);
        logic              bad;
        logic [CODE_W-1:0] ctrl;
        bad  = 1'b0;
        ctrl = ALU_ADD;
        case (f3)
            3'b000:  ctrl = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b111:  ctrl = ALU_AND;
            3'b110:  ctrl = ALU_OR;
            3'b100:  ctrl = ALU_XOR;
            3'b010:  ctrl = ALU_SLT;
            3'b001:  ctrl = ALU_SLL;
            3'b101:  begin
                if (f7b5) bad  = 1'b1;
                else      ctrl = ALU_SRL;
            end
            default: bad = 1'b1;
        endcase
        return {bad, ctrl};
    endfunction

    // Decode the ALU operation for both execute flavours.
    always_comb begin
        alu_dec_r = alu_decode(bus_if.funct3, bus_if.funct7b5, 1'b1);
        alu_dec_i = alu_decode(bus_if.funct3, bus_if.funct7b5, 1'b0);
    end

    // State and sticky illegal flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_HALT) illegal_q <= 1'b1;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = A_PC;
        alu_src_b  = B_RS2;
        result_src = R_ALUOUT;
        imm_sel    = IMM_I;
        alu_ctrl   = ALU_ADD;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            // PC+4 is computed while the fetch is outstanding. It is committed on mem_ready.
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = A_PC;
                alu_src_b  = B_FOUR;
                result_src = R_ALU;
                if (bus_if.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end

            // The branch/jump target OldPC+imm is computed speculatively into ALUOut.
            S_DECODE: begin
                alu_src_a = A_OLDPC;
                alu_src_b = B_IMM;
                imm_sel   = (bus_if.op == OP_JAL) ? IMM_J : IMM_B;
                case (bus_if.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BRANCH;
`ifdef RV_UTYPE_EN
                    OP_LUI, OP_AUIPC:  state_d = S_UTYPE;
`endif
                    default:           state_d = S_HALT;
                endcase
            end

            S_MEMADR: begin
                alu_src_a = A_RS1;
                alu_src_b = B_IMM;
                imm_sel   = (bus_if.op == OP_STORE) ? IMM_S : IMM_I;
                state_d   = (bus_if.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus_if.mem_ready) state_d = S_MEMWB;
            end

            S_MEMWB: begin
                result_src = R_RDATA;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (bus_if.mem_ready) state_d = S_FETCH;
            end

            S_EXECR: begin
                alu_src_a = A_RS1;
                alu_src_b = B_RS2;
                if (alu_dec_r[CODE_W]) begin
                    state_d = S_HALT;
                end else begin
                    alu_ctrl = alu_dec_r[CODE_W-1:0];
                    state_d  = S_ALUWB;
                end
            end

            S_EXECI: begin
                alu_src_a = A_RS1;
                alu_src_b = B_IMM;
                imm_sel   = IMM_I;
                if (alu_dec_i[CODE_W]) begin
                    state_d = S_HALT;
                end else begin
                    alu_ctrl = alu_dec_i[CODE_W-1:0];
                    state_d  = S_ALUWB;
                end
            end

            S_ALUWB: begin
                result_src = R_ALUOUT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end

            // The PC takes the target held in ALUOut while the ALU forms the link value OldPC+4.
            S_JAL: begin
                alu_src_a  = A_OLDPC;
                alu_src_b  = B_FOUR;
                result_src = R_ALUOUT;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end

            S_BRANCH: begin
                alu_src_a  = A_RS1;
                alu_src_b  = B_RS2;
                alu_ctrl   = ALU_SUB;
                result_src = R_ALUOUT;
                case (bus_if.funct3)
                    3'b000: begin
                        pc_write = bus_if.zero;
                        state_d  = S_FETCH;
                    end
                    3'b001: begin
                        pc_write = ~bus_if.zero;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_HALT;
                endcase
            end

`ifdef RV_UTYPE_EN
            // lui adds the immediate to zero. auipc adds it to OldPC.
            S_UTYPE: begin
                imm_sel   = IMM_U;
                alu_src_b = B_IMM;
                alu_src_a = (bus_if.op == OP_LUI) ? A_ZERO : A_OLDPC;
                state_d   = S_ALUWB;
            end
`endif

            S_HALT: state_d = S_HALT;

            default: state_d = S_IDLE;
        endcase
    end

    assign bus_if.mem_req    = mem_req;
    assign bus_if.mem_write  = mem_write;
    assign bus_if.adr_src    = adr_src;
    assign bus_if.ir_write   = ir_write;
    assign bus_if.pc_write   = pc_write;
    assign bus_if.reg_write  = reg_write;
    assign bus_if.alu_src_a  = alu_src_a;
    assign bus_if.alu_src_b  = alu_src_b;
    assign bus_if.result_src = result_src;
    assign bus_if.imm_sel    = imm_sel;
    assign bus_if.alu_ctrl   = alu_ctrl;
    assign bus_if.illegal    = illegal_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: bench for rv_multicycle_ctrl.
// The stimulus side builds, for each instruction, the sequence of control words the core
// should show on every cycle. It works from the instruction class, the memory stall counts
// and the zero flag. The words go into a queue. A monitor on the falling edge pops one word
// per cycle and compares it with the DUT.
module tb_rv_multicycle_ctrl;
    localparam int unsigned VEC_W = 19;
    typedef logic [VEC_W-1:0] vec_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR = 3'd3;
    localparam logic [2:0] A_XOR = 3'd4, A_SLT = 3'd5, A_SLL = 3'd6, A_SRL = 3'd7;
    localparam logic [2:0] IM_I = 3'd0, IM_S = 3'd1, IM_B = 3'd2, IM_U = 3'd3, IM_J = 3'd4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rv_multicycle_ctrl_if bus ();
    rv_multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus_if(bus));

    vec_t  sb_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;
    vec_t  exp_v, got_v;
    string exp_n;

    // The field order of a control word is:
    // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, a, b, result_src, imm_sel, alu_ctrl, illegal}
    function automatic vec_t pk(input logic mreq, input logic mwr, input logic adr,
                                input logic irw, input logic pcw, input logic rw,
                                input logic [1:0] a, input logic [1:0] b, input logic [1:0] rs,
                                input logic [2:0] imm, input logic [2:0] alu, input logic ill);
        return {mreq, mwr, adr, irw, pcw, rw, a, b, rs, imm, alu, ill};
    endfunction

    function automatic vec_t dut_vec();
        return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.imm_sel,
                bus.alu_ctrl, bus.illegal};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected ALU operation from the funct3 table. The return value is {unsupported, op}.
    function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic f7, input logic is_r);
        logic [2:0] tbl [8];
        logic       legal;
        logic [2:0] ctrl;
        tbl   = '{A_ADD, A_SLL, A_SLT, A_ADD, A_XOR, A_SRL, A_OR, A_AND};
        legal = !((f3 == 3'd3) || (f3 == 3'd5 && f7));
        ctrl  = legal ? tbl[f3] : A_ADD;
        if (f3 == 3'd0 && is_r && f7) ctrl = A_SUB;
        return {!legal, ctrl};
    endfunction

    // Monitor: one expected control word per cycle while the queue holds entries.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            exp_n = name_q.pop_front();
            got_v = dut_vec();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL %s got=%05h exp=%05h t=%0t", exp_n, got_v, exp_v, $time);
            end
        end
    end

    task automatic step(input logic rdy, input logic z, input vec_t e, input string n);
        bus.mem_ready = rdy;
        bus.zero      = z;
        sb_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string n);
        checks++;
        if (dut_vec() !== '0) begin
            failures++;
            $display("FAIL %s got=%05h exp=00000 t=%0t", n, dut_vec(), $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_zero("reset_now");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(rb(), rb(), '0, "idle");
    endtask

    task automatic halt_hold(input int n);
        repeat (n) step(rb(), rb(), pk(0,0,0,0,0,0,2'b00,2'b00,2'b00,IM_I,A_ADD,1), "halt");
    endtask

    // Runs one instruction. zsel is -1 for a random zero flag, otherwise the forced value.
    // abort=1 on a load asserts reset in the middle of MEMREAD.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input int fstall, input int mstall, input int zsel,
                             input bit abort, output bit halted);
        bit         is_ld, is_st, is_r, is_i, is_j, is_b, is_u, known;
        logic [3:0] ad;
        logic       z, pcw;
        vec_t       wb_alu, mreq_rd, mreq_wr;
        halted  = 1'b0;
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        is_ld = (op == OP_LOAD);
        is_st = (op == OP_STORE);
        is_r  = (op == OP_RTYPE);
        is_i  = (op == OP_ITYPE);
        is_j  = (op == OP_JAL);
        is_b  = (op == OP_BRANCH);
`ifdef RV_UTYPE_EN
        is_u  = (op == OP_LUI) || (op == OP_AUIPC);
`else
        is_u  = 1'b0;
`endif
        known   = is_ld | is_st | is_r | is_i | is_j | is_b | is_u;
        wb_alu  = pk(0,0,0,0,0,1,2'b00,2'b00,2'b00,IM_I,A_ADD,0);
        mreq_rd = pk(1,0,1,0,0,0,2'b00,2'b00,2'b00,IM_I,A_ADD,0);
        mreq_wr = pk(1,1,1,0,0,0,2'b00,2'b00,2'b00,IM_I,A_ADD,0);

        repeat (fstall) step(1'b0, rb(), pk(1,0,0,0,0,0,2'b00,2'b10,2'b10,IM_I,A_ADD,0), "fetch_stall");
        step(1'b1, rb(), pk(1,0,0,1,1,0,2'b00,2'b10,2'b10,IM_I,A_ADD,0), "fetch");
        step(rb(), rb(), pk(0,0,0,0,0,0,2'b01,2'b01,2'b00,is_j ? IM_J : IM_B,A_ADD,0), "decode");

        if (!known) begin
            halted = 1'b1;
        end else if (is_ld || is_st) begin
            step(rb(), rb(), pk(0,0,0,0,0,0,2'b10,2'b01,2'b00,is_ld ? IM_I : IM_S,A_ADD,0), "memadr");
            if (is_ld && abort) begin
                bus.mem_ready = 1'b0;
                sb_q.push_back(mreq_rd);
                name_q.push_back("memread_before_reset");
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                check_zero("reset_mid_memread");
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                step(rb(), rb(), '0, "idle_after_reset");
            end else if (is_ld) begin
                repeat (mstall) step(1'b0, rb(), mreq_rd, "memread_stall");
                step(1'b1, rb(), mreq_rd, "memread");
                step(rb(), rb(), pk(0,0,0,0,0,1,2'b00,2'b00,2'b01,IM_I,A_ADD,0), "memwb");
            end else begin
                repeat (mstall) step(1'b0, rb(), mreq_wr, "memwrite_stall");
                step(1'b1, rb(), mreq_wr, "memwrite");
            end
        end else if (is_r || is_i) begin
            ad = alu_ref(f3, f7, is_r);
            step(rb(), rb(), pk(0,0,0,0,0,0,2'b10,is_r ? 2'b00 : 2'b01,2'b00,IM_I,ad[2:0],0),
                 is_r ? "execr" : "execi");
            if (ad[3]) halted = 1'b1;
            else       step(rb(), rb(), wb_alu, "aluwb");
        end else if (is_j) begin
            step(rb(), rb(), pk(0,0,0,0,1,0,2'b01,2'b10,2'b00,IM_I,A_ADD,0), "jal");
            step(rb(), rb(), wb_alu, "aluwb_link");
        end else if (is_b) begin
            z   = (zsel < 0) ? rb() : 1'(zsel);
            pcw = (f3 == 3'd0) ? z : ((f3 == 3'd1) ? ~z : 1'b0);
            step(rb(), z, pk(0,0,0,0,pcw,0,2'b10,2'b00,2'b00,IM_I,A_SUB,0), "branch");
            if (f3 > 3'd1) halted = 1'b1;
        end else begin
            step(rb(), rb(), pk(0,0,0,0,0,0,(op == OP_LUI) ? 2'b11 : 2'b01,2'b01,2'b00,IM_U,A_ADD,0), "utype");
            step(rb(), rb(), wb_alu, "aluwb_u");
        end
    endtask

    task automatic rand_instr(output logic [6:0] op, output logic [2:0] f3, output logic f7);
        int k;
        k  = $urandom_range(0, 99);
        f3 = 3'($urandom_range(0, 7));
        f7 = ($urandom_range(0, 3) == 0);
        if      (k < 15) op = OP_LOAD;
        else if (k < 27) op = OP_STORE;
        else if (k < 47) op = OP_RTYPE;
        else if (k < 67) op = OP_ITYPE;
        else if (k < 75) op = OP_JAL;
        else if (k < 88) begin
            op = OP_BRANCH;
            if ($urandom_range(0, 5) != 0) f3 = 3'($urandom_range(0, 1));
        end
        else if (k < 96) op = ($urandom_range(0, 1) == 0) ? OP_LUI : OP_AUIPC;
        else if (k < 98) op = OP_SYSTEM;
        else             op = 7'($urandom_range(0, 127));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1);
    end

    initial begin
        bit         h;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0;
        bus.zero = 1'b0; bus.mem_ready = 1'b0;
        #1;
        do_reset();

        // Directed sequence.
        run_instr(OP_RTYPE,  3'd0, 1'b0, 0, 0, -1, 1'b0, h);
        run_instr(OP_RTYPE,  3'd0, 1'b1, 0, 0, -1, 1'b0, h);
        run_instr(OP_LOAD,   3'd2, 1'b0, 0, 2, -1, 1'b0, h);
        run_instr(OP_BRANCH, 3'd0, 1'b0, 0, 0,  1, 1'b0, h);
        run_instr(OP_BRANCH, 3'd0, 1'b0, 0, 0,  0, 1'b0, h);
        run_instr(OP_BRANCH, 3'd1, 1'b0, 0, 0,  0, 1'b0, h);
        run_instr(OP_JAL,    3'd0, 1'b0, 0, 0, -1, 1'b0, h);
        run_instr(OP_STORE,  3'd2, 1'b0, 1, 1, -1, 1'b0, h);
        run_instr(OP_ITYPE,  3'd5, 1'b0, 0, 0, -1, 1'b0, h);
        run_instr(OP_LUI,    3'd0, 1'b0, 0, 0, -1, 1'b0, h);
        if (h) begin
            halt_hold(5);
            do_reset();
        end
        run_instr(OP_AUIPC,  3'd0, 1'b0, 0, 0, -1, 1'b0, h);
        if (h) begin
            halt_hold(3);
            do_reset();
        end
        run_instr(OP_SYSTEM, 3'd0, 1'b0, 0, 0, -1, 1'b0, h);
        halt_hold(20);
        do_reset();
        run_instr(OP_LOAD,   3'd2, 1'b0, 0, 0, -1, 1'b1, h);
        run_instr(OP_RTYPE,  3'd3, 1'b0, 0, 0, -1, 1'b0, h);
        halt_hold(3);
        do_reset();

        // Random episodes. Each one ends in HALT or after a fixed number of instructions.
        for (int ep = 0; ep < 30; ep++) begin
            for (int n = 0; n < 25; n++) begin
                rand_instr(op, f3, f7);
                run_instr(op, f3, f7,
                          ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                          ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                          -1, ($urandom_range(0, 15) == 0), h);
                if (h) begin
                    halt_hold($urandom_range(1, 6));
                    break;
                end
            end
            do_reset();
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
